// File: rtl/key_switch_input_pio_pkg.sv
// Shared constants and bus request type for the key/switch input PIO.
package key_switch_input_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Decoded Avalon strobes for one bus cycle.
  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [1:0] addr;
  } bus_req_t;

endpackage

// File: rtl/key_switch_input_pio_if.sv
// Avalon-MM slave bus bundle for the input PIO (word addressed, read latency 1).
interface key_switch_input_pio_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/key_switch_input_pio_input_sync.sv
// Multi-flop synchronizer for the external inputs plus a previous-sample register
// feeding a combinational edge detector.
module key_switch_input_pio_input_sync
  import key_switch_input_pio_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] edges
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0]                  prev_reg;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
      prev_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_port};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign data_in = sync_reg[SYNC_STAGES-1];

  always_comb begin
    rise  = data_in & ~prev_reg;
    fall  = ~data_in & prev_reg;
    edges = rise;
    case (EDGE_TYPE)
      EDGE_FALL: edges = fall;
      EDGE_ANY:  edges = rise | fall;
      default:   edges = rise;
    endcase
  end

endmodule

// File: rtl/key_switch_input_pio.sv
// Avalon-MM input PIO: synchronized level register, sticky edge capture with
// write-1-to-clear, per-bit interrupt mask and a registered level interrupt.
module key_switch_input_pio
  import key_switch_input_pio_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  key_switch_input_pio_if.slave bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  bus_req_t         req;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] clear_mask;
  logic [WIDTH-1:0] irqmask_reg;
  logic [WIDTH-1:0] irqmask_next;
  logic [WIDTH-1:0] edgecap_reg;
  logic [WIDTH-1:0] edgecap_next;
  logic [31:0]      read_mux;
  logic [31:0]      readdata_reg;
  logic             irq_reg;
  logic             unused_wdata;

  key_switch_input_pio_input_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .data_in (data_in),
    .edges   (edges)
  );

  assign req.rd   = bus.chipselect & ~bus.read_n;
  assign req.wr   = bus.chipselect & ~bus.write_n;
  assign req.addr = bus.address;

  // Upper writedata bits beyond WIDTH carry no meaning for this block.
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    clear_mask = '0;
    if (req.wr && req.addr == ADDR_EDGECAP) begin
      clear_mask = bus.writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    irqmask_next = irqmask_reg;
    if (req.wr && req.addr == ADDR_IRQMASK) begin
      irqmask_next = bus.writedata[WIDTH-1:0];
    end
  end

  // A new edge on a bit being cleared in the same cycle keeps the bit set.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_edgecap
      assign edgecap_next[gi] = edges[gi] | (edgecap_reg[gi] & ~clear_mask[gi]);
    end
  endgenerate

  always_comb begin
    read_mux = '0;
    case (req.addr)
      ADDR_DATA:    read_mux[WIDTH-1:0] = data_in;
      ADDR_IRQMASK: read_mux[WIDTH-1:0] = irqmask_reg;
      ADDR_EDGECAP: read_mux[WIDTH-1:0] = edgecap_reg;
      default:      read_mux = '0;
    endcase
  end

  // Read mux samples the pre-write register values, so a same-cycle
  // read and write of one register returns the old contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_reg  <= '0;
      edgecap_reg  <= '0;
      readdata_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      irqmask_reg <= irqmask_next;
      edgecap_reg <= edgecap_next;
      irq_reg     <= |(edgecap_reg & irqmask_reg);
      if (req.rd) begin
        readdata_reg <= read_mux;
      end
    end
  end

  assign bus.readdata = readdata_reg;
  assign irq          = irq_reg;

endmodule

// File: tb/tb_key_switch_input_pio.sv
// Scoreboard bench: a rising-edge and an any-edge instance share stimulus and are
// compared against an input-history reference model.
module tb_key_switch_input_pio;
  import key_switch_input_pio_pkg::*;

  localparam int W = 16;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  in_port;
  logic          irq0;
  logic          irq2;

  logic [1:0]    addr;
  logic          cs;
  logic          rd_n;
  logic          wr_n;
  logic [31:0]   wdata;

  key_switch_input_pio_if bus0 ();
  key_switch_input_pio_if bus2 ();

  assign bus0.address = addr;  assign bus2.address = addr;
  assign bus0.chipselect = cs; assign bus2.chipselect = cs;
  assign bus0.read_n = rd_n;   assign bus2.read_n = rd_n;
  assign bus0.write_n = wr_n;  assign bus2.write_n = wr_n;
  assign bus0.writedata = wdata; assign bus2.writedata = wdata;

  key_switch_input_pio #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(EDGE_RISE)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port), .irq(irq0)
  );

  key_switch_input_pio #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(EDGE_ANY)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_port), .irq(irq2)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]  a;
    logic [31:0] r0;
    logic [31:0] r2;
  } rd_exp_t;

  rd_exp_t       sb[$];
  logic [W-1:0]  hist [0:S];
  logic [W-1:0]  m_ec0 = '0;
  logic [W-1:0]  m_ec2 = '0;
  logic [W-1:0]  m_mask = '0;
  logic          m_irq0 = 1'b0;
  logic          m_irq2 = 1'b0;
  logic          rd_valid = 1'b0;
  logic [W-1:0]  m_d;
  logic [W-1:0]  m_p;
  logic          m_rise;
  logic          m_fall;
  logic          m_clr;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] model_read(input logic [1:0] a, input logic [W-1:0] d,
                                             input logic [W-1:0] msk, input logic [W-1:0] ec);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0:    r[W-1:0] = d;
      2'd2:    r[W-1:0] = msk;
      2'd3:    r[W-1:0] = ec;
      default: r = '0;
    endcase
    return r;
  endfunction

  // The level seen by software is in_port delayed by S sampled clocks; an edge is
  // a difference between that level and the one a clock older.
  initial begin
    for (int j = 0; j <= S; j++) hist[j] = '0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int j = 0; j <= S; j++) hist[j] = '0;
        m_ec0 = '0; m_ec2 = '0; m_mask = '0;
        m_irq0 = 1'b0; m_irq2 = 1'b0;
        rd_valid = 1'b0;
        sb.delete();
      end else begin
        m_d = hist[S-1];
        m_p = hist[S];
        rd_valid = cs && !rd_n;
        if (rd_valid) begin
          sb.push_back('{a: addr, r0: model_read(addr, m_d, m_mask, m_ec0),
                         r2: model_read(addr, m_d, m_mask, m_ec2)});
        end
        m_irq0 = |(m_ec0 & m_mask);
        m_irq2 = |(m_ec2 & m_mask);
        for (int b = 0; b < W; b++) begin
          m_rise = m_d[b] && !m_p[b];
          m_fall = !m_d[b] && m_p[b];
          m_clr  = cs && !wr_n && addr == 2'd3 && wdata[b];
          if (m_rise) m_ec0[b] = 1'b1;
          else if (m_clr) m_ec0[b] = 1'b0;
          if (m_rise || m_fall) m_ec2[b] = 1'b1;
          else if (m_clr) m_ec2[b] = 1'b0;
        end
        if (cs && !wr_n && addr == 2'd2) m_mask = wdata[W-1:0];
        for (int j = S; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = in_port;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      n_checks++;
      if (irq0 !== m_irq0) begin
        n_fail++;
        $display("FAIL irq_rise actual=%0b required=%0b t=%0t", irq0, m_irq0, $time);
      end
      n_checks++;
      if (irq2 !== m_irq2) begin
        n_fail++;
        $display("FAIL irq_any actual=%0b required=%0b t=%0t", irq2, m_irq2, $time);
      end
      if (!reset_n) begin
        n_checks++;
        if (bus0.readdata !== 32'h0 || bus2.readdata !== 32'h0) begin
          n_fail++;
          $display("FAIL reset_readdata actual=%08h/%08h required=00000000 t=%0t",
                   bus0.readdata, bus2.readdata, $time);
        end
      end else if (rd_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_empty actual=read seen required=no read t=%0t", $time);
        end else begin
          e = sb.pop_front();
          $display("read addr=%0d rise=%08h any=%08h exp=%08h/%08h t=%0t",
                   e.a, bus0.readdata, bus2.readdata, e.r0, e.r2, $time);
          if (bus0.readdata !== e.r0 || bus2.readdata !== e.r2) begin
            n_fail++;
            $display("FAIL read_addr%0d actual=%08h/%08h required=%08h/%08h t=%0t",
                     e.a, bus0.readdata, bus2.readdata, e.r0, e.r2, $time);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_op(input logic [1:0] a, input logic do_rd, input logic do_wr,
                        input logic [31:0] d);
    addr = a; wdata = d; cs = 1'b1; rd_n = !do_rd; wr_n = !do_wr;
    @(negedge clk);
    cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    bus_op(a, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_op(a, 1'b0, 1'b1, d);
  endtask

  initial begin
    reset_n = 1'b0; in_port = 16'hA5A5;
    cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1; addr = 2'd0; wdata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    bus_read(ADDR_DATA);
    bus_write(ADDR_EDGECAP, 32'hFFFF);
    in_port = 16'h0000;
    idle(4);
    bus_write(ADDR_EDGECAP, 32'hFFFF);
    bus_read(ADDR_EDGECAP);

    // rising capture with mask cleared
    in_port = 16'h0011;
    idle(4);
    bus_read(ADDR_EDGECAP);
    bus_read(ADDR_EDGECAP);
    bus_read(ADDR_RSVD);

    // interrupt path
    bus_write(ADDR_IRQMASK, 32'h0001);
    bus_read(ADDR_IRQMASK);
    idle(2);
    bus_write(ADDR_EDGECAP, 32'h0001);
    idle(1);
    bus_read(ADDR_EDGECAP);

    // clear racing a freshly detected edge on bit 0
    in_port[0] = 1'b0;
    idle(4);
    bus_write(ADDR_EDGECAP, 32'hFFFF);
    in_port[0] = 1'b1;
    idle(2);
    bus_write(ADDR_EDGECAP, 32'h0001);
    bus_read(ADDR_EDGECAP);
    idle(2);

    // falling edge on bit 4 is seen only by the any-edge instance
    bus_write(ADDR_EDGECAP, 32'hFFFF);
    in_port = 16'h0001;
    idle(4);
    bus_read(ADDR_EDGECAP);

    // same-cycle read/write, ignored writes, upper bits dropped
    bus_op(ADDR_IRQMASK, 1'b1, 1'b1, 32'hABCD_1234);
    bus_read(ADDR_IRQMASK);
    bus_write(ADDR_DATA, 32'hFFFF_FFFF);
    bus_write(ADDR_RSVD, 32'hFFFF_FFFF);
    bus_read(ADDR_DATA);
    bus_read(ADDR_RSVD);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = 16'($urandom);
      case ($urandom_range(0, 4))
        0:       idle(1);
        1, 2:    bus_read(2'($urandom_range(0, 3)));
        3:       bus_write(2'($urandom_range(0, 3)), $urandom);
        default: bus_op(2'($urandom_range(0, 3)), 1'b1, 1'b1, $urandom);
      endcase
    end

    // reset mid-operation with irq asserted
    in_port = 16'h0000;
    idle(4);
    bus_write(ADDR_EDGECAP, 32'hFFFF);
    bus_write(ADDR_IRQMASK, 32'hFFFF);
    in_port = 16'h0003;
    idle(4);
    in_port = 16'h0000;
    idle(4);
    bus_read(ADDR_EDGECAP);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b1;
    idle(4);
    bus_read(ADDR_IRQMASK);
    bus_read(ADDR_EDGECAP);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
